pic_irq_sequencer: RTL and testbench

PIC_IRQ_SEQUENCER -- requirements
Module: pic_irq_sequencer

---
 rtl/pic_irq_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_pic_irq_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_irq_sequencer.sv
// pic_irq_sequencer
//   8-level interrupt request sequencer: captures requests on IR0..IR7
//   (edge or level), resolves fully nested priority against the in-service
//   register, and runs the two-acknowledge vector handshake with the CPU.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   ir[7:0]             interrupt request lines
//   imr[7:0]            mask (1 = masked)
//   ltim                1 = level-triggered, 0 = edge-triggered
//   aeoi                automatic EOI on the second acknowledge
//   vector_base[4:0]    vector bits T7..T3
//   inta                one-cycle acknowledge strobe
//   eoi_ns / eoi_sp     non-specific / specific EOI strobes
//   eoi_level[2:0]      level cleared by eoi_sp
//   rotate              (ROTATE_PRIO_EN only) rotate priority on EOI
//   int_out             interrupt request to CPU
//   vector_out[7:0]     {vector_base, level}, held between pulses
//   vector_oe           vector_out valid for one cycle
//   irr[7:0], isr[7:0]  request / in-service registers
//
// Build option
//   ROTATE_PRIO_EN      adds the rotate input and a rotating priority pointer;
//                       without it the pointer is fixed at 7 (IR0 highest).
module pic_irq_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ir,
    input  logic [7:0] imr,
    input  logic       ltim,
    input  logic       aeoi,
    input  logic [4:0] vector_base,
    input  logic       inta,
    input  logic       eoi_ns,
    input  logic       eoi_sp,
    input  logic [2:0] eoi_level,
`ifdef ROTATE_PRIO_EN
    input  logic       rotate,
`endif
    output logic       int_out,
    output logic [7:0] vector_out,
    output logic       vector_oe,
    output logic [7:0] irr,
    output logic [7:0] isr
);

    typedef enum logic [1:0] {IDLE, PEND, VEC} state_t;

    state_t     state, state_n;
    logic       int_out_n;
    logic       latch_fire;
    logic       vec_fire;

    logic [7:0] ir_q;
    logic [2:0] ptr;
    logic [2:0] level;
    logic       spurious;

    logic [7:0] req;
    logic       win_valid;
    logic [2:0] win_lvl;
    logic       isr_hi_valid;
    logic [2:0] isr_hi_lvl;

    logic [7:0] isr_clr;
    logic [7:0] isr_set;
    logic [7:0] irr_clr;
    logic [7:0] irr_n;

    assign req = irr & ~imr;

    // Walk levels from highest to lowest priority (starting just above the
    // pointer). The first in-service level found blocks itself and everything
    // below it, which gives the strictly-higher nesting rule.
    always_comb begin : prio_scan
        logic [2:0] lvl;
        win_valid    = 1'b0;
        win_lvl      = '0;
        isr_hi_valid = 1'b0;
        isr_hi_lvl   = '0;
        lvl          = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            lvl = ptr + 3'd1 + k[2:0];
            if (!isr_hi_valid && isr[lvl]) begin
                isr_hi_valid = 1'b1;
                isr_hi_lvl   = lvl;
            end
            if (!win_valid && !isr_hi_valid && req[lvl]) begin
                win_valid = 1'b1;
                win_lvl   = lvl;
            end
        end
    end

    always_comb begin
        state_n    = state;
        int_out_n  = 1'b0;
        latch_fire = 1'b0;
        vec_fire   = 1'b0;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    state_n   = PEND;
                    int_out_n = 1'b1;
                end
            end
            PEND: begin
                int_out_n = 1'b1;
                if (inta) begin
                    latch_fire = 1'b1;
                    int_out_n  = 1'b0;
                    state_n    = VEC;
                end
            end
            VEC: begin
                if (inta) begin
                    vec_fire = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            int_out <= 1'b0;
        end else begin
            state   <= state_n;
            int_out <= int_out_n;
        end
    end

    // Clears are gathered first and applied before sets, so an EOI landing on
    // the same bit as a first-acknowledge grant leaves that bit set.
    always_comb begin
        isr_clr = '0;
        isr_set = '0;
        irr_clr = '0;
        if (eoi_sp) begin
            isr_clr[eoi_level] = 1'b1;
        end else if (eoi_ns && isr_hi_valid) begin
            isr_clr[isr_hi_lvl] = 1'b1;
        end
        if (vec_fire && aeoi && !spurious) begin
            isr_clr[level] = 1'b1;
        end
        if (latch_fire && win_valid) begin
            isr_set[win_lvl] = 1'b1;
            irr_clr[win_lvl] = 1'b1;
        end
    end

    // Edge mode holds a captured request while the line stays high; either
    // mode drops it as soon as the line goes low.
    assign irr_n = ~irr_clr & ir & ({8{ltim}} | ~ir_q | irr);

    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q       <= '0;
            irr        <= '0;
            isr        <= '0;
            level      <= 3'd7;
            spurious   <= 1'b0;
            vector_out <= '0;
            vector_oe  <= 1'b0;
        end else begin
            ir_q      <= ir;
            irr       <= irr_n;
            isr       <= (isr & ~isr_clr) | isr_set;
            vector_oe <= vec_fire;
            if (latch_fire) begin
                level    <= win_valid ? win_lvl : 3'd7;
                spurious <= ~win_valid;
            end
            if (vec_fire) begin
                vector_out <= {vector_base, level};
            end
        end
    end

`ifdef ROTATE_PRIO_EN
    logic [2:0] ptr_n;

    // An automatic EOI overrides a coincident non-specific EOI as the new
    // lowest-priority level.
    always_comb begin
        ptr_n = ptr;
        if (rotate) begin
            if (!eoi_sp && eoi_ns && isr_hi_valid) begin
                ptr_n = isr_hi_lvl;
            end
            if (vec_fire && aeoi && !spurious) begin
                ptr_n = level;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 3'd7;
        end else begin
            ptr <= ptr_n;
        end
    end
`else
    assign ptr = 3'd7;
`endif

endmodule

// File: tb/tb_pic_irq_sequencer.sv
`timescale 1ns/1ps
module tb_pic_irq_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ir;
    logic [7:0] imr;
    logic       ltim;
    logic       aeoi;
    logic [4:0] vector_base;
    logic       inta;
    logic       eoi_ns;
    logic       eoi_sp;
    logic [2:0] eoi_level;
`ifdef ROTATE_PRIO_EN
    logic       rotate;
`endif
    logic       int_out;
    logic [7:0] vector_out;
    logic       vector_oe;
    logic [7:0] irr;
    logic [7:0] isr;

    pic_irq_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .ir         (ir),
        .imr        (imr),
        .ltim       (ltim),
        .aeoi       (aeoi),
        .vector_base(vector_base),
        .inta       (inta),
        .eoi_ns     (eoi_ns),
        .eoi_sp     (eoi_sp),
        .eoi_level  (eoi_level),
`ifdef ROTATE_PRIO_EN
        .rotate     (rotate),
`endif
        .int_out    (int_out),
        .vector_out (vector_out),
        .vector_oe  (vector_oe),
        .irr        (irr),
        .isr        (isr)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Requests and in-service bits as plain bit vectors, priority as a rank
    // number (0 = highest) derived from the lowest-priority pointer.
    bit [7:0] m_irr, m_isr, m_ir_q, m_vout;
    bit       m_int, m_voe, m_spur;
    int       m_phase;   // 0 waiting for request, 1 request raised, 2 vector due
    int       m_level;
    int       m_ptr;

    function automatic int rank(input int lvl);
        return (lvl - m_ptr + 15) % 8;
    endfunction

    task automatic model_step();
        int       hi_rank = 8;
        int       hi_lvl  = -1;
        int       win     = -1;
        int       win_rank = 8;
        int       new_ptr;
        bit [7:0] clr  = '0;
        bit [7:0] setb = '0;
        bit [7:0] gclr = '0;
        bit [7:0] nirr;
        if (rst) begin
            m_irr = '0; m_isr = '0; m_ir_q = '0; m_vout = '0;
            m_int = 0; m_voe = 0; m_spur = 0; m_phase = 0; m_level = 7; m_ptr = 7;
            return;
        end
        new_ptr = m_ptr;
        for (int i = 0; i < 8; i++)
            if (m_isr[i] && rank(i) < hi_rank) begin hi_rank = rank(i); hi_lvl = i; end
        for (int i = 0; i < 8; i++)
            if (m_irr[i] && !imr[i] && rank(i) < hi_rank && rank(i) < win_rank) begin
                win = i; win_rank = rank(i);
            end
        if (eoi_sp) clr[eoi_level] = 1;
        else if (eoi_ns && hi_lvl >= 0) begin
            clr[hi_lvl] = 1;
`ifdef ROTATE_PRIO_EN
            if (rotate) new_ptr = hi_lvl;
`endif
        end
        m_voe = 0;
        case (m_phase)
            0: if (win >= 0) begin m_phase = 1; m_int = 1; end
            1: if (inta) begin
                m_spur  = (win < 0);
                m_level = (win < 0) ? 7 : win;
                if (win >= 0) begin setb[win] = 1; gclr[win] = 1; end
                m_int   = 0;
                m_phase = 2;
            end
            default: if (inta) begin
                m_vout  = {vector_base, 3'(m_level)};
                m_voe   = 1;
                m_phase = 0;
                if (aeoi && !m_spur) begin
                    clr[m_level] = 1;
`ifdef ROTATE_PRIO_EN
                    if (rotate) new_ptr = m_level;
`endif
                end
            end
        endcase
        for (int i = 0; i < 8; i++) begin
            if (gclr[i] || !ir[i])        nirr[i] = 0;
            else if (ltim || !m_ir_q[i])  nirr[i] = 1;
            else                          nirr[i] = m_irr[i];
        end
        m_irr  = nirr;
        m_isr  = (m_isr & ~clr) | setb;
        m_ir_q = ir;
        m_ptr  = new_ptr;
    endtask

    // One clock: inputs already driven, model advances on the edge, outputs
    // compared 1 ns later.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        chk("int_out",    {7'b0, int_out},   {7'b0, m_int});
        chk("vector_oe",  {7'b0, vector_oe}, {7'b0, m_voe});
        chk("vector_out", vector_out, m_vout);
        chk("irr",        irr,        m_irr);
        chk("isr",        isr,        m_isr);
    endtask

    task automatic do_reset();
        rst = 1; inta = 0; eoi_ns = 0; eoi_sp = 0; ir = '0;
        step();
        rst = 0;
        chk("rst.irr", irr, 8'h00);
        chk("rst.isr", isr, 8'h00);
        chk("rst.int_out", {7'b0, int_out}, 8'h00);
        chk("rst.vector_oe", {7'b0, vector_oe}, 8'h00);
        chk("rst.vector_out", vector_out, 8'h00);
    endtask

    // Raise one line (edge mode), wait a bounded time for int_out, run both
    // acknowledges, then drop the line.
    task automatic serve(input int lvl);
        int n = 0;
        ir = ir | 8'(1 << lvl);
        do begin step(); n++; end while (!int_out && n < 8);
        checks++;
        if (!int_out) begin
            failures++;
            $display("FAIL serve%0d.timeout: int_out=0 expected 1", lvl);
        end
        inta = 1; step();
        inta = 1; step();
        inta = 0;
        ir = ir & ~8'(1 << lvl);
    endtask

    typedef struct {
        logic [7:0] ir;
        logic       inta, eoi_ns, eoi_sp;
        logic [2:0] eoi_lvl;
        logic       aeoi;
        logic       exp_int, exp_oe;
        logic [7:0] exp_vout, exp_irr, exp_isr;
    } vec_t;

    vec_t tv[17];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tv[0]  = '{8'h08, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h08, 8'h00};
        tv[1]  = '{8'h08, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h08, 8'h00};
        tv[2]  = '{8'h08, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h08};
        tv[3]  = '{8'h08, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h08};
        tv[4]  = '{8'h08, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'h83, 8'h00, 8'h08};
        tv[5]  = '{8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h83, 8'h00, 8'h08};
        tv[6]  = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h83, 8'h00, 8'h00};
        tv[7]  = '{8'h01, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h83, 8'h01, 8'h00};
        tv[8]  = '{8'h01, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 8'h83, 8'h01, 8'h00};
        tv[9]  = '{8'h01, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h83, 8'h00, 8'h01};
        tv[10] = '{8'h01, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 8'h80, 8'h00, 8'h00};
        tv[11] = '{8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h80, 8'h00, 8'h00};
        tv[12] = '{8'h02, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h80, 8'h02, 8'h00};
        tv[13] = '{8'h02, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 8'h80, 8'h02, 8'h00};
        tv[14] = '{8'h02, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 8'h80, 8'h00, 8'h02};
        tv[15] = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'h81, 8'h00, 8'h02};
        tv[16] = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 8'h81, 8'h00, 8'h00};

        rst = 1; ir = '0; imr = '0; ltim = 0; aeoi = 0; vector_base = 5'h10;
        inta = 0; eoi_ns = 0; eoi_sp = 0; eoi_level = '0;
`ifdef ROTATE_PRIO_EN
        rotate = 0;
`endif
        #2;
        do_reset();

        // basic grant/vector, AEOI, specific EOI coincident with first inta
        for (int n = 0; n < 17; n++) begin
            ir = tv[n].ir; inta = tv[n].inta; eoi_ns = tv[n].eoi_ns;
            eoi_sp = tv[n].eoi_sp; eoi_level = tv[n].eoi_lvl; aeoi = tv[n].aeoi;
            step();
            chk($sformatf("tv%0d.int_out", n),    {7'b0, int_out},   {7'b0, tv[n].exp_int});
            chk($sformatf("tv%0d.vector_oe", n),  {7'b0, vector_oe}, {7'b0, tv[n].exp_oe});
            chk($sformatf("tv%0d.vector_out", n), vector_out, tv[n].exp_vout);
            chk($sformatf("tv%0d.irr", n),        irr,        tv[n].exp_irr);
            chk($sformatf("tv%0d.isr", n),        isr,        tv[n].exp_isr);
        end
        inta = 0; eoi_ns = 0; eoi_sp = 0; aeoi = 0;

        // nested blocking, released by non-specific EOI (level mode)
        do_reset();
        ltim = 1; ir = 8'h04;
        step(); step();
        inta = 1; step(); step(); inta = 0;
        chk("nest.isr_served", isr, 8'h04);
        ir = 8'h24;
        step(); step();
        chk("nest.blocked", {7'b0, int_out}, 8'h00);
        eoi_ns = 1; step(); eoi_ns = 0;
        chk("nest.eoi_isr", isr, 8'h00);
        step();
        chk("nest.int_raised", {7'b0, int_out}, 8'h01);
        inta = 1; step();
        chk("nest.ir2_first", isr, 8'h04);
        step(); inta = 0;
        ir = 8'h00; eoi_ns = 1; step(); eoi_ns = 0;
        ltim = 0;

        // spurious IR7 after withdrawn request
        do_reset();
        ir = 8'h08; step(); step();
        ir = 8'h00; step();
        inta = 1; step();
        chk("spur.isr", isr, 8'h00);
        step(); inta = 0;
        chk("spur.vector_out", vector_out, 8'h87);
        chk("spur.vector_oe", {7'b0, vector_oe}, 8'h01);

        // reset during VEC aborts the vector
        do_reset();
        ir = 8'h08; step(); step();
        inta = 1; step();
        chk("abort.isr_before", isr, 8'h08);
        rst = 1; step(); rst = 0;
        chk("abort.vector_oe", {7'b0, vector_oe}, 8'h00);
        chk("abort.isr", isr, 8'h00);
        step();
        chk("abort.idle_inta", {7'b0, vector_oe}, 8'h00);
        inta = 0; ir = 8'h00; step();

        // eoi_sp wins over coincident eoi_ns
        do_reset();
        serve(5);
        serve(2);
        chk("both.isr_nested", isr, 8'h24);
        eoi_ns = 1; eoi_sp = 1; eoi_level = 3'd5; step();
        eoi_sp = 0;
        chk("both.sp_wins", isr, 8'h04);
        step(); eoi_ns = 0;
        chk("both.ns_clear", isr, 8'h00);

`ifdef ROTATE_PRIO_EN
        // rotation: after IR1 is retired with rotate=1, IR2 outranks IR1
        do_reset();
        rotate = 1;
        serve(1);
        eoi_ns = 1; step(); eoi_ns = 0;
        ir = 8'h06; step(); step();
        inta = 1; step();
        chk("rot.ir2_first", isr, 8'h04);
        step(); inta = 0;
        ir = 8'h00; eoi_ns = 1; step(); eoi_ns = 0;
        rotate = 0;
`endif

        // randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n % 250 == 0) begin
                ltim = 1'($urandom_range(0, 1));
                aeoi = 1'($urandom_range(0, 1));
                vector_base = 5'($urandom);
`ifdef ROTATE_PRIO_EN
                rotate = 1'($urandom_range(0, 1));
`endif
            end
            if ($urandom_range(0, 3) == 0) ir = ir ^ 8'(1 << $urandom_range(0, 7));
            imr       = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
            inta      = ($urandom_range(0, 3) == 0);
            eoi_ns    = ($urandom_range(0, 15) == 0);
            eoi_sp    = ($urandom_range(0, 31) == 0);
            eoi_level = 3'($urandom);
            rst       = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 0; inta = 0; eoi_ns = 0; eoi_sp = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
